// File: rtl/clock_ctrl.sv
// clock_ctrl: one-second tick prescaler and user time-set state machine
// for the 12-hour BCD time counter. Edits hours, then minutes, then commits
// the edited time with a one-cycle load strobe.
module clock_ctrl #(
  parameter int unsigned TICK_DIV  = 10000000,
  parameter int unsigned BLINK_DIV = 2500000,
  parameter int unsigned TIMEOUT   = 300000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [6:0] cur_hh,
  input  logic [7:0] cur_mm,
  input  logic       cur_pm,
  output logic       tick,
  output logic       load,
  output logic [6:0] ld_hh,
  output logic [7:0] ld_mm,
  output logic       ld_pm,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int unsigned PW = $clog2(TICK_DIV + 1);
  localparam int unsigned BW = $clog2(BLINK_DIV + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SET_HH = 2'd1,
    ST_SET_MM = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [BW-1:0] bl_cnt, bl_cnt_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic          tick_n, load_n, blink_n, ld_pm_n;
  logic [6:0]    ld_hh_n;
  logic [7:0]    ld_mm_n;
  logic [7:0]    hh_step;
  logic [7:0]    mm_step;
  logic          btn_any;
  logic          set_stay;

  // BCD hour increment 01..12; returns {pm_toggle, next_hh}
  function automatic logic [7:0] hh_inc(input logic [6:0] hh);
    logic [2:0] t;
    logic [3:0] u;
    logic       ok;
    t  = hh[6:4];
    u  = hh[3:0];
    ok = ((t == 3'd0) && (u != 4'd0) && (u <= 4'd9)) ||
         ((t == 3'd1) && (u <= 4'd2));
    if (!ok)                return {1'b0, 7'h01};
    else if (hh == 7'h11)   return {1'b1, 7'h12};
    else if (hh == 7'h12)   return {1'b0, 7'h01};
    else if (u == 4'd9)     return {1'b0, t + 3'd1, 4'd0};
    else                    return {1'b0, t, u + 4'd1};
  endfunction

  // BCD minute increment 00..59, no carry out
  function automatic logic [7:0] mm_inc(input logic [7:0] mm);
    logic [3:0] t;
    logic [3:0] u;
    t = mm[7:4];
    u = mm[3:0];
    if ((t > 4'd5) || (u > 4'd9)) return 8'h00;
    else if (mm == 8'h59)         return 8'h00;
    else if (u == 4'd9)           return {t + 4'd1, 4'd0};
    else                          return {t, u + 4'd1};
  endfunction

  assign hh_step = hh_inc(ld_hh);
  assign mm_step = mm_inc(ld_mm);
  assign btn_any = btn_mode | btn_inc;
  assign mode    = state;

  // Next-state, edit registers, prescaler, timeout and blink control
  always_comb begin
    state_n  = state;
    presc_n  = '0;
    bl_cnt_n = '0;
    to_cnt_n = '0;
    tick_n   = 1'b0;
    load_n   = 1'b0;
    blink_n  = 1'b0;
    ld_hh_n  = ld_hh;
    ld_mm_n  = ld_mm;
    ld_pm_n  = ld_pm;
    set_stay = 1'b0;

    case (state)
      ST_RUN: begin
        if (btn_mode) begin
          state_n = ST_SET_HH;
          ld_hh_n = cur_hh;
          ld_mm_n = cur_mm;
          ld_pm_n = cur_pm;
        end
      end
      ST_SET_HH: begin
        if (btn_mode) begin
          state_n = ST_SET_MM;
        end else if (btn_inc) begin
          ld_hh_n = hh_step[6:0];
          ld_pm_n = ld_pm ^ hh_step[7];
        end else if (to_cnt == TO_MAX) begin
          state_n = ST_RUN;
        end
      end
      ST_SET_MM: begin
        if (btn_mode) begin
          state_n = ST_COMMIT;
        end else if (btn_inc) begin
          ld_mm_n = mm_step;
        end else if (to_cnt == TO_MAX) begin
          state_n = ST_RUN;
        end
      end
      ST_COMMIT: begin
        state_n = ST_RUN;
      end
      default: begin
        state_n = ST_RUN;
      end
    endcase

    // Prescaler only runs while staying in RUN; any other path restarts it at 0
    if ((state == ST_RUN) && (state_n == ST_RUN)) begin
      presc_n = (presc == PRESC_MAX) ? '0 : presc + PW'(1);
    end
    tick_n = (state_n == ST_RUN) && (presc_n == PRESC_MAX);
    load_n = (state_n == ST_COMMIT);

    // Timeout and blink advance only while remaining in the same set state;
    // entering SET_HH or SET_MM starts both from zero
    set_stay = ((state_n == ST_SET_HH) || (state_n == ST_SET_MM)) && (state_n == state);
    if (set_stay) begin
      to_cnt_n = btn_any ? '0 : to_cnt + TW'(1);
      if (bl_cnt == BLINK_MAX) begin
        bl_cnt_n = '0;
        blink_n  = ~blink;
      end else begin
        bl_cnt_n = bl_cnt + BW'(1);
        blink_n  = blink;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_RUN;
      presc  <= '0;
      bl_cnt <= '0;
      to_cnt <= '0;
      tick   <= 1'b0;
      load   <= 1'b0;
      blink  <= 1'b0;
      ld_hh  <= 7'h12;
      ld_mm  <= 8'h00;
      ld_pm  <= 1'b0;
    end else begin
      state  <= state_n;
      presc  <= presc_n;
      bl_cnt <= bl_cnt_n;
      to_cnt <= to_cnt_n;
      tick   <= tick_n;
      load   <= load_n;
      blink  <= blink_n;
      ld_hh  <= ld_hh_n;
      ld_mm  <= ld_mm_n;
      ld_pm  <= ld_pm_n;
    end
  end

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed testbench for clock_ctrl with TICK_DIV=4, BLINK_DIV=2, TIMEOUT=20.
module tb_clock_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode;
  logic       btn_inc;
  logic [6:0] cur_hh;
  logic [7:0] cur_mm;
  logic       cur_pm;
  logic       tick;
  logic       load;
  logic [6:0] ld_hh;
  logic [7:0] ld_mm;
  logic       ld_pm;
  logic [1:0] mode;
  logic       blink;

  int n_tests = 0;
  int n_fail  = 0;

  clock_ctrl #(.TICK_DIV(4), .BLINK_DIV(2), .TIMEOUT(20)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hh(cur_hh), .cur_mm(cur_mm), .cur_pm(cur_pm),
    .tick(tick), .load(load), .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_pm(ld_pm),
    .mode(mode), .blink(blink)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
    cur_hh = 7'h11; cur_mm = 8'h58; cur_pm = 1'b0;
    repeat (3) step();
    n_tests++;
    if ({mode, tick, load, blink, ld_pm} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got mode=%0d tick=%b load=%b blink=%b pm=%b, expected all 0", mode, tick, load, blink, ld_pm);
    end
    n_tests++;
    if (ld_hh !== 7'h12 || ld_mm !== 8'h00) begin
      n_fail++; $display("FAIL reset_ld: got %h:%h expected 12:00", ld_hh, ld_mm);
    end
  endtask

  // Release cycle is cycle 1; ticks expected in cycles 4, 8, 12
  task automatic test_free_run();
    logic exp_t;
    reset = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      if (c > 1) step();
      exp_t = (c == 4) || (c == 8) || (c == 12);
      n_tests++;
      if (tick !== exp_t || mode !== 2'd0 || load !== 1'b0 || blink !== 1'b0) begin
        n_fail++; $display("FAIL free_run c%0d: got tick=%b mode=%0d load=%b blink=%b expected tick=%b mode=0 load=0 blink=0", c, tick, mode, load, blink, exp_t);
      end
    end
  endtask

  task automatic test_full_set();
    cur_hh = 7'h11; cur_mm = 8'h58; cur_pm = 1'b0;
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    n_tests++;
    if (mode !== 2'd1 || ld_hh !== 7'h11 || ld_mm !== 8'h58 || ld_pm !== 1'b0 || blink !== 1'b0) begin
      n_fail++; $display("FAIL set_capture: got mode=%0d %h:%h pm=%b blink=%b expected 1 11:58 pm=0 blink=0", mode, ld_hh, ld_mm, ld_pm, blink);
    end
    btn_inc = 1'b1; step(); btn_inc = 1'b0;
    n_tests++;
    if (ld_hh !== 7'h12 || ld_pm !== 1'b1) begin
      n_fail++; $display("FAIL set_hh_inc: got %h pm=%b expected 12 pm=1", ld_hh, ld_pm);
    end
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    n_tests++;
    if (mode !== 2'd2 || blink !== 1'b0) begin
      n_fail++; $display("FAIL set_to_mm: got mode=%0d blink=%b expected 2 0", mode, blink);
    end
    btn_inc = 1'b1; step();
    n_tests++;
    if (ld_mm !== 8'h59) begin
      n_fail++; $display("FAIL set_mm_inc1: got %h expected 59", ld_mm);
    end
    step(); btn_inc = 1'b0;
    n_tests++;
    if (ld_mm !== 8'h00 || ld_hh !== 7'h12) begin
      n_fail++; $display("FAIL set_mm_wrap: got %h:%h expected 12:00", ld_hh, ld_mm);
    end
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    n_tests++;
    if (load !== 1'b1 || mode !== 2'd3 || ld_hh !== 7'h12 || ld_mm !== 8'h00 || ld_pm !== 1'b1) begin
      n_fail++; $display("FAIL commit_load: got load=%b mode=%0d %h:%h pm=%b expected 1 3 12:00 pm=1", load, mode, ld_hh, ld_mm, ld_pm);
    end
    step();
    n_tests++;
    if (load !== 1'b0 || mode !== 2'd0 || tick !== 1'b0) begin
      n_fail++; $display("FAIL commit_run: got load=%b mode=%0d tick=%b expected 0 0 0", load, mode, tick);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      n_tests++;
      if (tick !== (i == 3) || load !== 1'b0) begin
        n_fail++; $display("FAIL commit_tick%0d: got tick=%b load=%b expected tick=%b load=0", i, tick, load, (i == 3));
      end
    end
  endtask

  task automatic test_hour_wrap();
    logic [6:0] exp_hh [12];
    exp_hh = '{7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06,
               7'h07, 7'h08, 7'h09, 7'h10, 7'h11, 7'h12};
    cur_hh = 7'h12; cur_mm = 8'h30; cur_pm = 1'b0;
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    btn_inc = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      n_tests++;
      if (ld_hh !== exp_hh[i] || ld_pm !== (i == 11)) begin
        n_fail++; $display("FAIL hour_wrap%0d: got %h pm=%b expected %h pm=%b", i, ld_hh, ld_pm, exp_hh[i], (i == 11));
      end
    end
    btn_inc = 1'b0;
    btn_mode = 1'b1; step(); step(); btn_mode = 1'b0;
    step();
    n_tests++;
    if (mode !== 2'd0) begin
      n_fail++; $display("FAIL hour_wrap_exit: got mode=%0d expected 0", mode);
    end
    cur_hh = 7'h1A; cur_mm = 8'h5A; cur_pm = 1'b1;
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    btn_inc = 1'b1; step(); btn_inc = 1'b0;
    n_tests++;
    if (ld_hh !== 7'h01 || ld_pm !== 1'b1) begin
      n_fail++; $display("FAIL hour_nonbcd: got %h pm=%b expected 01 pm=1", ld_hh, ld_pm);
    end
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    btn_inc = 1'b1; step(); btn_inc = 1'b0;
    n_tests++;
    if (ld_mm !== 8'h00) begin
      n_fail++; $display("FAIL min_nonbcd: got %h expected 00", ld_mm);
    end
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    cur_hh = 7'h03; cur_mm = 8'h15; cur_pm = 1'b0;
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      n_tests++;
      if (k < 20 && (mode !== 2'd1 || blink !== ((k / 2) % 2 == 1) || load !== 1'b0)) begin
        n_fail++; $display("FAIL timeout_hold%0d: got mode=%0d blink=%b load=%b expected 1 %b 0", k, mode, blink, load, ((k / 2) % 2 == 1));
      end else if (k == 20 && (mode !== 2'd0 || load !== 1'b0 || blink !== 1'b0 || ld_hh !== 7'h03)) begin
        n_fail++; $display("FAIL timeout_exit: got mode=%0d load=%b blink=%b hh=%h expected 0 0 0 03", mode, load, blink, ld_hh);
      end
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      n_tests++;
      if (tick !== (i == 3)) begin
        n_fail++; $display("FAIL timeout_tick%0d: got %b expected %b", i, tick, (i == 3));
      end
    end
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    repeat (19) step();
    btn_inc = 1'b1; step(); btn_inc = 1'b0;
    n_tests++;
    if (mode !== 2'd1 || ld_hh !== 7'h04) begin
      n_fail++; $display("FAIL timeout_btn_clear: got mode=%0d hh=%h expected 1 04", mode, ld_hh);
    end
    repeat (19) step();
    n_tests++;
    if (mode !== 2'd1) begin
      n_fail++; $display("FAIL timeout_rearm_hold: got mode=%0d expected 1", mode);
    end
    step();
    n_tests++;
    if (mode !== 2'd0 || load !== 1'b0) begin
      n_fail++; $display("FAIL timeout_rearm_exit: got mode=%0d load=%b expected 0 0", mode, load);
    end
  endtask

  task automatic test_priority();
    cur_hh = 7'h05; cur_mm = 8'h20; cur_pm = 1'b1;
    btn_mode = 1'b1; step();
    btn_inc = 1'b1; step(); btn_mode = 1'b0; btn_inc = 1'b0;
    n_tests++;
    if (mode !== 2'd2 || ld_hh !== 7'h05 || ld_mm !== 8'h20) begin
      n_fail++; $display("FAIL prio_mode_wins: got mode=%0d %h:%h expected 2 05:20", mode, ld_hh, ld_mm);
    end
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    step();
    btn_inc = 1'b1; step(); btn_inc = 1'b0;
    n_tests++;
    if (mode !== 2'd0 || ld_hh !== 7'h05 || ld_mm !== 8'h20 || ld_pm !== 1'b1) begin
      n_fail++; $display("FAIL prio_inc_in_run: got mode=%0d %h:%h pm=%b expected 0 05:20 pm=1", mode, ld_hh, ld_mm, ld_pm);
    end
  endtask

  task automatic test_reset_mid_set();
    cur_hh = 7'h07; cur_mm = 8'h44; cur_pm = 1'b1;
    btn_mode = 1'b1; step(); step(); btn_mode = 1'b0;
    btn_inc = 1'b1; step(); btn_inc = 1'b0;
    step(); step();
    n_tests++;
    if (mode !== 2'd2 || ld_mm !== 8'h45) begin
      n_fail++; $display("FAIL midset_pre: got mode=%0d mm=%h expected 2 45", mode, ld_mm);
    end
    reset = 1'b1; step();
    n_tests++;
    if (mode !== 2'd0 || load !== 1'b0 || ld_hh !== 7'h12 || ld_mm !== 8'h00 || ld_pm !== 1'b0 || blink !== 1'b0) begin
      n_fail++; $display("FAIL midset_reset: got mode=%0d load=%b %h:%h pm=%b blink=%b expected 0 0 12:00 0 0", mode, load, ld_hh, ld_mm, ld_pm, blink);
    end
    reset = 1'b0;
    step();
    n_tests++;
    if (load !== 1'b0 || mode !== 2'd0) begin
      n_fail++; $display("FAIL midset_after: got load=%b mode=%0d expected 0 0", load, mode);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_full_set();
    test_hour_wrap();
    test_timeout();
    test_priority();
    test_reset_mid_set();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
